busca_instrucao: RTL
====================

# busca_instrucao

Instruction fetch stage that sits directly upstream of the instruction memory. It owns the program counter, drives the memory's word address, and captures the asynchronously read instruction word into the IF/ID pipeline register for the decode stage. It handles branch redirects, pipeline stalls, a start gate so the memory can be loaded before execution, and a halt on a sentinel instruction. It also counts issued instructions.

## Interface
Parameters:
- ADDR_W, 10, word-address width; must match the instruction memory depth (1024 words).
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value after reset.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  leaves IDLE and begins fetching.
- STALL  in  1  holds PC and IF/ID register.
- BRANCH  in  1  redirects PC to BRANCH_TARGET.
- BRANCH_TARGET  in  ADDR_W  redirect address (word).
- IMEM_Q  in  DATA_W  instruction word read from memory at IMEM_ADDR.
- IMEM_ADDR  out  ADDR_W  equals PC register (no combinational path from inputs).
- IF_INSTR  out  DATA_W  registered instruction.
- IF_PC  out  ADDR_W  address IF_INSTR was fetched from.
- IF_PC_NEXT  out  ADDR_W  IF_PC + 1, modulo 2^ADDR_W.
- IF_VALID  out  1  IF_INSTR is a real instruction for decode.
- HALTED  out  1  high while in HALT state.
- FETCH_COUNT  out  32  number of instructions issued (IF_VALID set by a fetch) since reset.

## Operation
- FSM states: IDLE, RUN, HALT. Reset enters IDLE.
- IDLE: PC held at RESET_PC; IF_VALID=0; START=1 -> RUN next edge. No fetch occurs on the START edge.
- RUN, per edge, priority highest first:
  - BRANCH=1: PC<=BRANCH_TARGET; IF_VALID<=0 (squash wrong-path word); IF_INSTR/IF_PC unchanged. Overrides STALL.
  - STALL=1: PC, IF_INSTR, IF_PC, IF_VALID, FETCH_COUNT all hold.
  - IMEM_Q==HALT_WORD: state<=HALT; PC holds; IF_VALID<=0; halt word is never issued.
  - otherwise: IF_INSTR<=IMEM_Q; IF_PC<=PC; IF_VALID<=1; PC<=PC+1; FETCH_COUNT+=1.
- HALT: PC, IF_INSTR, IF_PC hold; IF_VALID=0; START, BRANCH, STALL ignored; only RST exits.
- PC arithmetic is ADDR_W bits, wraps 1023->0 silently; FETCH_COUNT wraps at 2^32.
- Only the registered IMEM_ADDR is used by the memory; this block never drives memory writes.

## Timing
- Reset values (after the RST edge): state=IDLE, PC=IMEM_ADDR=RESET_PC, IF_INSTR=0, IF_PC=0, IF_PC_NEXT=1, IF_VALID=0, HALTED=0, FETCH_COUNT=0.
- RST high on any edge overrides every other input, including mid-branch or in HALT.
- Fetch latency: word at PC appears on IF_INSTR with IF_VALID=1 one edge after PC is presented; sustained throughput one instruction per cycle.
- First valid instruction: START sampled at edge N -> IF_VALID=1 after edge N+1 with IF_PC=RESET_PC.
- Branch penalty: BRANCH at edge N -> IF_VALID=0 after edge N, target instruction valid after edge N+1.
- HALTED rises after the edge at which HALT_WORD was sampled; IF_VALID is 0 from that same edge.
- IF_PC_NEXT is combinational from IF_PC.

## Test plan
- Reset/start: memory words 0..3 = 0x11,0x22,0x33,0x44; RST, then START one cycle -> IF_INSTR 0x11,0x22,0x33 on successive cycles, IF_PC 0,1,2, IF_VALID=1, FETCH_COUNT=3.
- Stall: STALL high 2 cycles while IF_INSTR=0x22 -> IF_INSTR, IF_PC=1, IMEM_ADDR=2 and FETCH_COUNT held; resumes with 0x33.
- Branch with simultaneous stall: BRANCH=1, STALL=1, BRANCH_TARGET=0x100, mem[0x100]=0xABCD -> next cycle IF_VALID=0, IMEM_ADDR=0x100; following cycle IF_INSTR=0xABCD, IF_PC=0x100.
- Halt: mem[5]=0xFFFFFFFF -> after word 4 issued, HALTED=1, IF_VALID=0, IMEM_ADDR=5, FETCH_COUNT=5; BRANCH and START then ignored for 10 cycles.
- Wrap-around: branch to 1023, mem[1023]=0x77, mem[0]=0x11 -> IF_PC=1023 with 0x77, IF_PC_NEXT=0, next IF_PC=0 with 0x11.
- Reset mid-run: assert RST while IF_VALID=1 and PC=0x40 -> all outputs at reset values after that edge; state IDLE until START.

Source files
------------

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: owns the PC, addresses the instruction memory,
// and registers the asynchronously read word into the IF/ID register.
module busca_instrucao #(
  parameter int unsigned        ADDR_W    = 10,
  parameter int unsigned        DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD = '1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STALL,
  input  logic              BRANCH,
  input  logic [ADDR_W-1:0] BRANCH_TARGET,
  input  logic [DATA_W-1:0] IMEM_Q,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [DATA_W-1:0] IF_INSTR,
  output logic [ADDR_W-1:0] IF_PC,
  output logic [ADDR_W-1:0] IF_PC_NEXT,
  output logic              IF_VALID,
  output logic              HALTED,
  output logic [31:0]       FETCH_COUNT
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [DATA_W-1:0] instr, instr_nx;
  logic [ADDR_W-1:0] if_pc, if_pc_nx;
  logic              valid, valid_nx;
  logic [31:0]       count, count_nx;

  // State and IF/ID register update; reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= '0;
      if_pc <= '0;
      valid <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      instr <= instr_nx;
      if_pc <= if_pc_nx;
      valid <= valid_nx;
      count <= count_nx;
    end
  end

  // Next-state and datapath selection: branch > stall > halt word > fetch.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    if_pc_nx = if_pc;
    valid_nx = valid;
    count_nx = count;
    unique case (state)
      IDLE: begin
        pc_nx    = RESET_PC;
        valid_nx = 1'b0;
        if (START) state_nx = RUN;
      end
      RUN: begin
        if (BRANCH) begin
          // The word on IMEM_Q belongs to the wrong path, so it is dropped.
          pc_nx    = BRANCH_TARGET;
          valid_nx = 1'b0;
        end else if (STALL) begin
          // Everything holds: defaults already cover it.
        end else if (IMEM_Q == HALT_WORD) begin
          state_nx = HALT;
          valid_nx = 1'b0;
        end else begin
          instr_nx = IMEM_Q;
          if_pc_nx = pc;
          valid_nx = 1'b1;
          pc_nx    = pc + ADDR_W'(1);
          count_nx = count + 32'd1;
        end
      end
      HALT: begin
        valid_nx = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  assign IMEM_ADDR   = pc;
  assign IF_INSTR    = instr;
  assign IF_PC       = if_pc;
  assign IF_PC_NEXT  = if_pc + ADDR_W'(1);
  assign IF_VALID    = valid;
  assign HALTED      = (state == HALT);
  assign FETCH_COUNT = count;

endmodule
